// File: rtl/cic2_comb_decimator.sv
// CIC2 comb/decimation stage: samples the free-running integrator every OSR clocks,
// applies two first-difference combs and hands results out over valid/ready.
module cic2_comb_decimator #(
    parameter int IN_W  = 32,
    parameter int OSR   = 256,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [IN_W-1:0] din,
    output logic [IN_W-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            overrun,
    input  logic            clr_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSR - 1);
    localparam logic [1:0]       PRIMED  = 2'd2;

    logic [CNT_W-1:0] cnt;
    logic             strobe;
    logic [IN_W-1:0]  s_d;
    logic [IN_W-1:0]  c1;
    logic [IN_W-1:0]  c1_d;
    logic [IN_W-1:0]  result;
    logic             p1;
    logic [1:0]       prime;
    logic             load;

    assign strobe = en && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Comb stage 1 runs on the strobe; stage 2 completes one cycle later under p1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d  <= '0;
            c1   <= '0;
            c1_d <= '0;
            p1   <= 1'b0;
        end else begin
            p1 <= strobe;
            if (strobe) begin
                s_d <= din;
                c1  <= din - s_d;
            end
            if (p1) begin
                c1_d <= c1;
            end
        end
    end

    assign result = c1 - c1_d;

    // A stage-2 completion in flight when en drops still sees the old prime count.
    assign load = p1 && (prime == PRIMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime <= '0;
        end else if (!en) begin
            prime <= '0;
        end else if (p1 && (prime != PRIMED)) begin
            prime <= prime + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load && (!dout_valid || dout_ready)) begin
            dout       <= result;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (load && dout_valid && !dout_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic2_comb_decimator.sv
// Bench for cic2_comb_decimator (OSR=4): strobe-sample model with second differences,
// per-cycle output compare, plus directed literal checks.
module tb_cic2_comb_decimator;

    localparam int IN_W  = 32;
    localparam int OSR   = 4;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [IN_W-1:0] din = '0;
    logic [IN_W-1:0] dout;
    logic            dout_valid;
    logic            dout_ready = 1'b1;
    logic            overrun;
    logic            clr_overrun = 1'b0;

    always #5 clk = ~clk;

    cic2_comb_decimator #(.IN_W(IN_W), .OSR(OSR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned n = 0;
    int          mode = 0;
    logic        chk_on = 1'b0;

    function automatic logic [IN_W-1:0] stim(int md, int unsigned k);
        longint kk;
        kk = longint'(k);
        case (md)
            1:       return IN_W'(7 * kk);
            2:       return IN_W'(kk * (kk - 1) / 2) + 32'hFFFF_FF00;
            default: return IN_W'(kk * (kk - 1) / 2);
        endcase
    endfunction

    task automatic chk(string nm, logic [IN_W-1:0] act, logic [IN_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        n++;
        din = stim(mode, n);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!dout_valid && lat < 40);
        if (!dout_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: got no dout_valid expected one within 40 cycles at %0t", $time);
        end
    endtask

    task automatic restart(int md);
        en = 1'b0;
        tick();
        mode = md;
        n = 0;
        din = stim(mode, n);
        en = 1'b1;
    endtask

    // Model: every OSR-th enabled cycle is a strobe; from the third strobe of a
    // session the output is x[k] - 2x[k-1] + x[k-2], arriving one edge later.
    logic [IN_W-1:0] m_dout = '0;
    logic            m_valid = 1'b0;
    logic            m_ov = 1'b0;
    int              m_encnt = 0;
    logic [IN_W-1:0] samp[$];
    logic            pend_v = 1'b0;
    logic [IN_W-1:0] pend_val = '0;
    logic            ovs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout  = '0;
            m_valid = 1'b0;
            m_ov    = 1'b0;
            m_encnt = 0;
            pend_v  = 1'b0;
            samp.delete();
        end else begin
            ovs = pend_v && m_valid && !dout_ready;
            if (pend_v) begin
                if (!m_valid || dout_ready) begin
                    m_dout  = pend_val;
                    m_valid = 1'b1;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
            if (ovs) m_ov = 1'b1;
            else if (clr_overrun) m_ov = 1'b0;
            pend_v = 1'b0;
            if (en) begin
                if (m_encnt % OSR == OSR - 1) begin
                    samp.push_back(din);
                    if (samp.size() >= 3) begin
                        pend_val = samp[$] - samp[$-1] - samp[$-1] + samp[$-2];
                        pend_v   = 1'b1;
                    end
                end
                m_encnt++;
            end else begin
                m_encnt = 0;
                samp.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_valid", IN_W'(dout_valid), IN_W'(m_valid));
            chk("cyc_overrun", IN_W'(overrun), IN_W'(m_ov));
            chk("cyc_dout", dout, m_dout);
        end
    end

    initial begin
        int lat;
        int cntv;

        tick();
        tick();
        chk_on = 1'b1;
        chk("rst_dout", dout, 32'd0);
        chk("rst_valid", IN_W'(dout_valid), 32'd0);
        chk("rst_overrun", IN_W'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // All-ones integrator response: full scale OSR^2 = 16
        restart(0);
        wait_valid(lat);
        chk("ones_latency", IN_W'(lat), 32'd13);
        chk("ones_first", dout, 32'd16);
        cntv = 0;
        repeat (8) begin
            tick();
            if (dout_valid) cntv++;
        end
        chk("ones_pulses", IN_W'(cntv), 32'd2);
        chk("ones_dout", dout, 32'd16);

        // Linear ramp: second difference is zero
        restart(1);
        wait_valid(lat);
        chk("ramp_latency", IN_W'(lat), 32'd13);
        chk("ramp_dout", dout, 32'd0);
        repeat (2) begin
            wait_valid(lat);
            chk("ramp_dout", dout, 32'd0);
        end

        // Offset forces 32-bit wrap of the integrator mid-run
        restart(2);
        repeat (6) begin
            wait_valid(lat);
            chk("wrap_dout", dout, 32'd16);
        end

        // Backpressure across two results
        wait_valid(lat);
        dout_ready = 1'b0;
        repeat (3) tick();
        chk("bp_ovr_before", IN_W'(overrun), 32'd0);
        tick();
        chk("bp_valid_held", IN_W'(dout_valid), 32'd1);
        chk("bp_dout_held", dout, 32'd16);
        chk("bp_overrun", IN_W'(overrun), 32'd1);
        dout_ready = 1'b1;
        tick();
        chk("bp_consumed", IN_W'(dout_valid), 32'd0);
        dout_ready = 1'b0;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("bp_clr", IN_W'(overrun), 32'd0);

        // Accept and new result on the same edge
        wait_valid(lat);
        repeat (3) tick();
        dout_ready = 1'b1;
        tick();
        chk("sim_valid", IN_W'(dout_valid), 32'd1);
        chk("sim_overrun", IN_W'(overrun), 32'd0);
        chk("sim_dout", dout, 32'd16);

        // Async reset mid-conversion with overrun set
        dout_ready = 1'b0;
        wait_valid(lat);
        repeat (4) tick();
        chk("pre_rst_overrun", IN_W'(overrun), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, 32'd0);
        chk("arst_valid", IN_W'(dout_valid), 32'd0);
        chk("arst_overrun", IN_W'(overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        wait_valid(lat);
        chk("rst_latency", IN_W'(lat), 32'd13);
        chk("rst_dout_after", dout, 32'd16);

        // Enable toggle re-primes
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        wait_valid(lat);
        chk("en_latency", IN_W'(lat), 32'd13);
        chk("en_dout", dout, 32'd16);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cic2_comb_decimator.md
Name: cic2_comb_decimator

Overview:
- Downstream stage of the order-2 CIC integrator that consumes a 1-bit sigma-delta stream.
- Takes the free-running 32-bit integrator output every clock and decimates it by OSR.
- Applies two comb (first-difference) stages at the decimated rate, completing the CIC2 sinc² filter.
- Delivers one filtered sample per OSR input clocks over a valid/ready handshake to the readout/serialiser logic.

Parameters:
- IN_W, 32, width of the integrator data input and of all internal comb arithmetic.
- OSR, 256, decimation ratio; legal range 2..65535; full-scale output is OSR².
- CNT_W, 16, width of the decimation counter; must satisfy 2^CNT_W > OSR-1.

Ports:
- clk  in  1  single system clock, same clock as the integrator.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  conversion enable; low holds the block idle and clears priming.
- din  in  IN_W  integrator output, sampled on decimation strobes only.
- dout  out  IN_W  filtered, decimated sample.
- dout_valid  out  1  dout holds an unconsumed sample.
- dout_ready  in  1  consumer accepts dout when valid && ready at a rising clk edge.
- overrun  out  1  sticky flag: a sample was dropped due to backpressure.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Clocking and reset
  - One clock domain.
  - Reset is asynchronous and active-low. While rst_n=0: dout=0, dout_valid=0, overrun=0, and the counter, comb delay registers, priming count and pipeline valid are all 0.
  - Reset asserted mid-conversion discards all state. No partial output is produced after release.
- Decimation counter
  - cnt counts 0..OSR-1 while en=1, then wraps to 0.
  - While en=0, cnt is held at 0 and prime is cleared to 0.
  - strobe = en && (cnt == OSR-1). The first strobe occurs OSR cycles after en rises.
- Comb stage 1 (cycle of strobe)
  - s_d <= din.
  - c1 <= din - s_d.
- Comb stage 2 (next cycle, pipeline valid p1)
  - c1_d <= c1.
  - result = c1 - c1_d.
- Arithmetic
  - All subtraction is IN_W-bit modulo 2^IN_W (two's-complement wrap, no saturation).
  - This is required for correct CIC behaviour when the integrator wraps.
- Priming
  - prime is a 2-bit counter incremented on each stage-2 completion, saturating at 2.
  - The results of the first two strobes after en rises or after reset are discarded; their delay lines are still loaded.
  - From the third strobe onward, the result is offered at the output.
- Latency
  - result is registered into dout at the edge ending the cycle after the strobe cycle.
  - dout_valid=1 from 2 clocks after the strobe edge.
- Handshake
  - dout_valid stays high, and dout stays stable, until the cycle where dout_ready=1; dout_valid drops on the next edge unless a new result loads on that same edge.
  - New result arriving while dout_valid=1 and dout_ready=1 in the same cycle: load the new result and keep valid=1 (no bubble).
  - New result arriving while dout_valid=1 and dout_ready=0: drop the new result, keep the old dout, and set overrun=1.
- Overrun flag
  - overrun stays set until clr_overrun=1.
  - If clr_overrun and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- en deassertion
  - A sample already in the output register remains valid until consumed.
  - A result in the comb pipeline (p1) completes and is offered only if prime==2.
- Ready with no valid data
  - dout_ready is ignored when dout_valid=0.

Test Plan:
- OSR=4, en=1, din = n(n-1)/2 mod 2^32 at cycle n (the integrator response to all-ones) -> first valid dout appears at the third strobe; every dout=16 (OSR²); dout_valid pulses once per 4 clocks with ready held at 1.
- OSR=4, din = 7n (linear ramp) -> after priming, every dout=0.
- OSR=4, din = n(n-1)/2 + 0xFFFFFF00 (forces 32-bit wrap mid-run) -> every dout still 16; no glitch at the wrap.
- Backpressure: dout_ready=0 across two valid results -> dout holds the first value (16), overrun=1 after the second result; then dout_ready=1 for one cycle -> valid drops; clr_overrun=1 -> overrun=0.
- Simultaneous accept and new result (ready=1 on the exact load edge) -> dout updates, valid stays 1 continuously, overrun stays 0.
- Reset/enable: pulse rst_n=0 for 1 cycle between strobes -> all outputs 0 immediately (asynchronously); after release, two strobes are discarded before the next valid dout=16. Same priming check after en is toggled 1→0→1.
